// File: rtl/ber_ctrl_pkg.sv
// rtl/ber_ctrl_pkg.sv - shared types and constants for the BER measurement sequencer
package ber_ctrl_pkg;

    localparam int CNT_W = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SYNC    = 3'd2,
        S_MEASURE = 3'd3,
        S_SNAP    = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } berState;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_START = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_CLEAR = 2'd3
    } berCmd;

    // Read word select: bit 0 picks the 32-bit half, bits 2:1 pick the counter.
    localparam logic [2:0] SEL_ERR_I_LO  = 3'd0;
    localparam logic [2:0] SEL_ERR_I_HI  = 3'd1;
    localparam logic [2:0] SEL_BITS_I_LO = 3'd2;
    localparam logic [2:0] SEL_BITS_I_HI = 3'd3;
    localparam logic [2:0] SEL_ERR_Q_LO  = 3'd4;
    localparam logic [2:0] SEL_ERR_Q_HI  = 3'd5;
    localparam logic [2:0] SEL_BITS_Q_LO = 3'd6;
    localparam logic [2:0] SEL_BITS_Q_HI = 3'd7;

endpackage

// File: rtl/ber_ctrl_if.sv
// rtl/ber_ctrl_if.sv - command, read port and BER counter bundle of the sequencer
interface ber_ctrl_if;
    import ber_ctrl_pkg::*;

    logic             i_cmd_valid;
    logic [1:0]       i_cmd;
    logic [31:0]      i_window;
    logic             i_rd_en;
    logic [2:0]       i_rd_sel;
    logic [31:0]      o_rd_data;
    logic             o_rd_valid;
    logic             o_ber_reset;
    logic             o_ber_enable;
    logic             i_fase_ok_i;
    logic             i_fase_ok_q;
    logic [CNT_W-1:0] i_err_i;
    logic [CNT_W-1:0] i_bits_i;
    logic [CNT_W-1:0] i_err_q;
    logic [CNT_W-1:0] i_bits_q;
    logic [2:0]       o_state;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout;

    modport master (
        output i_cmd_valid, i_cmd, i_window, i_rd_en, i_rd_sel,
        output i_fase_ok_i, i_fase_ok_q, i_err_i, i_bits_i, i_err_q, i_bits_q,
        input  o_rd_data, o_rd_valid, o_ber_reset, o_ber_enable,
        input  o_state, o_busy, o_done, o_timeout
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_window, i_rd_en, i_rd_sel,
        input  i_fase_ok_i, i_fase_ok_q, i_err_i, i_bits_i, i_err_q, i_bits_q,
        output o_rd_data, o_rd_valid, o_ber_reset, o_ber_enable,
        output o_state, o_busy, o_done, o_timeout
    );

endinterface

// File: rtl/ber_snapshot.sv
// rtl/ber_snapshot.sv - atomic capture of the four BER counters and registered word read-out
module ber_snapshot
    import ber_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             i_reset,
    input  logic             capture,
    input  logic             clear,
    input  logic [CNT_W-1:0] errI,
    input  logic [CNT_W-1:0] bitsI,
    input  logic [CNT_W-1:0] errQ,
    input  logic [CNT_W-1:0] bitsQ,
    input  logic             rdEn,
    input  logic [2:0]       rdSel,
    output logic [31:0]      rdData,
    output logic             rdValid
);

    logic [CNT_W-1:0] snapErrI, snapBitsI, snapErrQ, snapBitsQ;
    logic [31:0]      word;

    // Clear beats capture so a CLEAR racing a snapshot leaves all zeros.
    always_ff @(posedge clock) begin
        if (i_reset || clear) begin
            snapErrI  <= '0;
            snapBitsI <= '0;
            snapErrQ  <= '0;
            snapBitsQ <= '0;
        end else if (capture) begin
            snapErrI  <= errI;
            snapBitsI <= bitsI;
            snapErrQ  <= errQ;
            snapBitsQ <= bitsQ;
        end
    end

    always_comb begin
        word = '0;
        case (rdSel)
            SEL_ERR_I_LO:  word = snapErrI[31:0];
            SEL_ERR_I_HI:  word = snapErrI[63:32];
            SEL_BITS_I_LO: word = snapBitsI[31:0];
            SEL_BITS_I_HI: word = snapBitsI[63:32];
            SEL_ERR_Q_LO:  word = snapErrQ[31:0];
            SEL_ERR_Q_HI:  word = snapErrQ[63:32];
            SEL_BITS_Q_LO: word = snapBitsQ[31:0];
            SEL_BITS_Q_HI: word = snapBitsQ[63:32];
            default:       word = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEn;
            if (rdEn) rdData <= word;
        end
    end

endmodule

// File: rtl/ber_ctrl.sv
// rtl/ber_ctrl.sv - BER measurement sequencer: clear, lock wait, windowed run, snapshot
// Optional BER_CTRL_AUTORESTART_EN: DONE rolls straight into a new window with the latched size.
module ber_ctrl
    import ber_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 4,
    parameter int SYNC_TIMEOUT = 1_000_000
) (
    input logic       clock,
    input logic       i_reset,
    ber_ctrl_if.slave bus
);

    localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [31:0] SYNC_LAST = 32'(SYNC_TIMEOUT - 1);

    berState     state, nextState;
    logic [31:0] window;
    logic [31:0] cycleCnt;
    logic        doneFlag, clearPulse;
    logic        cmdStart, cmdStop, cmdClear;
    logic        locked, windowHit, startAccept, captureStrobe;

    assign cmdStart  = bus.i_cmd_valid && (bus.i_cmd == CMD_START);
    assign cmdStop   = bus.i_cmd_valid && (bus.i_cmd == CMD_STOP);
    assign cmdClear  = bus.i_cmd_valid && (bus.i_cmd == CMD_CLEAR);
    assign locked    = bus.i_fase_ok_i && bus.i_fase_ok_q;
    assign windowHit = (window != '0)
                    && (bus.i_bits_i >= {32'd0, window})
                    && (bus.i_bits_q >= {32'd0, window});
    assign startAccept = cmdStart && !cmdClear
                      && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign captureStrobe = (state == S_SNAP) && !cmdClear;

    always_ff @(posedge clock) begin
        if (i_reset) state <= S_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState        = state;
        bus.o_state      = state;
        bus.o_ber_reset  = (state == S_CLEAR) || clearPulse;
        bus.o_ber_enable = (state == S_SYNC) || (state == S_MEASURE);
        bus.o_busy       = (state == S_CLEAR) || (state == S_SYNC)
                        || (state == S_MEASURE) || (state == S_SNAP);
        bus.o_done       = doneFlag;
        bus.o_timeout    = (state == S_ERROR);
        if (cmdClear) begin
            nextState = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERROR: if (cmdStart) nextState = S_CLEAR;
`ifdef BER_CTRL_AUTORESTART_EN
                S_DONE: nextState = cmdStop ? S_IDLE : S_CLEAR;
`else
                S_DONE: if (cmdStart) nextState = S_CLEAR;
`endif
                S_CLEAR: if (cycleCnt >= RST_LAST) nextState = S_SYNC;
                S_SYNC: begin
                    if (cmdStop)                    nextState = S_SNAP;
                    else if (locked)                nextState = S_MEASURE;
                    else if (cycleCnt >= SYNC_LAST) nextState = S_ERROR;
                end
                S_MEASURE: if (cmdStop || windowHit) nextState = S_SNAP;
                S_SNAP:    nextState = S_DONE;
                default:   nextState = S_IDLE;
            endcase
        end
    end

    // One saturating counter serves both CLEAR length and SYNC timeout; zeroed on every state change.
    always_ff @(posedge clock) begin
        if (i_reset || nextState != state) cycleCnt <= '0;
        else if (cycleCnt != '1)           cycleCnt <= cycleCnt + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            window     <= '0;
            doneFlag   <= 1'b0;
            clearPulse <= 1'b0;
        end else begin
            if (startAccept) window <= bus.i_window;
            doneFlag   <= captureStrobe;
            clearPulse <= cmdClear;
        end
    end

    ber_snapshot snapshot (
        .clock   (clock),
        .i_reset (i_reset),
        .capture (captureStrobe),
        .clear   (cmdClear),
        .errI    (bus.i_err_i),
        .bitsI   (bus.i_bits_i),
        .errQ    (bus.i_err_q),
        .bitsQ   (bus.i_bits_q),
        .rdEn    (bus.i_rd_en),
        .rdSel   (bus.i_rd_sel),
        .rdData  (bus.o_rd_data),
        .rdValid (bus.o_rd_valid)
    );

endmodule

// File: tb/tb_ber_ctrl.sv
// tb/tb_ber_ctrl.sv - self-checking bench for ber_ctrl (vector table, directed corners, random snapshots)
module tb_ber_ctrl;
    import ber_ctrl_pkg::*;

    localparam int RST_N = 4;
    localparam int TMO   = 100;

    logic clock = 1'b0;
    logic i_reset;
    always #5 clock = ~clock;

    ber_ctrl_if bus();

    ber_ctrl #(.RST_CYCLES(RST_N), .SYNC_TIMEOUT(TMO)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int nRun  = 0;
    int nFail = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] exp;
    } rdVec;
    rdVec        vecs[8];
    logic [63:0] model[4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nRun++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [31:0] w);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = c;
        bus.i_window    = w;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = CMD_NOP;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        for (int k = 0; k < bound && bus.o_state != s; k++) tick();
        check(name, bus.o_state, s);
    endtask

    task automatic read_word(input logic [2:0] sel, input logic [31:0] exp, input string name);
        bus.i_rd_en  = 1'b1;
        bus.i_rd_sel = sel;
        tick();
        bus.i_rd_en  = 1'b0;
        check({name, "_valid"}, bus.o_rd_valid, 1);
        check(name, bus.o_rd_data, exp);
    endtask

    task automatic set_counters(input logic [63:0] ei, input logic [63:0] bi,
                                input logic [63:0] eq, input logic [63:0] bq);
        bus.i_err_i  = ei;
        bus.i_bits_i = bi;
        bus.i_err_q  = eq;
        bus.i_bits_q = bq;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, nd, run, lastRun, dones;
        logic [31:0] orAll;
        logic [2:0]  rsel;
        logic [31:0] rexp;

        vecs[0] = '{3'd0, 32'h0000_0011};
        vecs[1] = '{3'd1, 32'h0000_0002};
        vecs[2] = '{3'd2, 32'd1000};
        vecs[3] = '{3'd3, 32'd0};
        vecs[4] = '{3'd4, 32'h0000_0022};
        vecs[5] = '{3'd5, 32'h0000_0003};
        vecs[6] = '{3'd6, 32'd1000};
        vecs[7] = '{3'd7, 32'h0000_0005};

        i_reset         = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = CMD_NOP;
        bus.i_window    = '0;
        bus.i_rd_en     = 1'b0;
        bus.i_rd_sel    = '0;
        bus.i_fase_ok_i = 1'b0;
        bus.i_fase_ok_q = 1'b0;
        set_counters(0, 0, 0, 0);
        tick();
        tick();
        check("rst_state", bus.o_state, S_IDLE);
        check("rst_ber_reset", bus.o_ber_reset, 0);
        check("rst_enable", bus.o_ber_enable, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_timeout", bus.o_timeout, 0);
        check("rst_rd_data", bus.o_rd_data, 0);
        check("rst_rd_valid", bus.o_rd_valid, 0);
        i_reset = 1'b0;
        tick();

`ifdef BER_CTRL_AUTORESTART_EN
        bus.i_fase_ok_i = 1'b1;
        bus.i_fase_ok_q = 1'b1;
        set_counters(3, 64, 4, 64);
        cmd(CMD_START, 64);
        run = 0; lastRun = 0; dones = 0;
        for (int k = 0; k < 400 && dones < 3; k++) begin
            if (bus.o_ber_reset) run++;
            else if (run != 0) begin lastRun = run; run = 0; end
            if (bus.o_done) begin
                check("ar_reset_len", lastRun, RST_N);
                lastRun = 0;
                dones++;
            end
            tick();
        end
        check("ar_dones", dones, 3);
        read_word(3'd2, 32'd64, "ar_bits_i");
        cmd(CMD_CLEAR, 0);
        check("ar_clear_idle", bus.o_state, S_IDLE);
`else
        // Lock, then a 1000-bit window.
        set_counters(64'h2_0000_0011, 0, 64'h3_0000_0022, 64'h5_0000_0000);
        cmd(CMD_START, 1000);
        check("start_state", bus.o_state, S_CLEAR);
        check("start_busy", bus.o_busy, 1);
        n = 0;
        for (int k = 0; k < 20 && bus.o_state == S_CLEAR; k++) begin
            n += int'(bus.o_ber_reset);
            tick();
        end
        check("clear_len", n, RST_N);
        check("sync_state", bus.o_state, S_SYNC);
        check("sync_enable", bus.o_ber_enable, 1);
        repeat (19) tick();
        check("sync_hold", bus.o_state, S_SYNC);
        bus.i_fase_ok_i = 1'b1;
        bus.i_fase_ok_q = 1'b1;
        tick();
        check("lock_measure", bus.o_state, S_MEASURE);
        for (int k = 1; k <= 9; k++) begin
            bus.i_bits_i = 64'(k * 100);
            bus.i_bits_q = 64'h5_0000_0000 + 64'(k * 100);
            tick();
        end
        check("no_early_snap", bus.o_state, S_MEASURE);
        bus.i_bits_i = 64'd1000;
        bus.i_bits_q = 64'h5_0000_03E8;
        tick();
        check("win_snap", bus.o_state, S_SNAP);
        check("snap_enable", bus.o_ber_enable, 0);
        tick();
        check("done_state", bus.o_state, S_DONE);
        check("done_pulse", bus.o_done, 1);
        tick();
        check("done_single", bus.o_done, 0);
        check("done_hold", bus.o_state, S_DONE);
        for (int i = 0; i < 8; i++) begin
            bus.i_rd_en  = 1'b1;
            bus.i_rd_sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d_valid", i), bus.o_rd_valid, 1);
            check($sformatf("vec%0d_data", i), bus.o_rd_data, vecs[i].exp);
        end
        bus.i_rd_en = 1'b0;
        tick();
        check("rd_idle_valid", bus.o_rd_valid, 0);
        check("rd_idle_hold", bus.o_rd_data, vecs[7].exp);

        // Unbounded window, START while busy, early STOP.
        cmd(CMD_START, 0);
        wait_state(S_MEASURE, 20, "w0_measure");
        set_counters(64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF);
        repeat (30) tick();
        check("w0_unbounded", bus.o_state, S_MEASURE);
        cmd(CMD_START, 5);
        check("busy_start_ignored", bus.o_state, S_MEASURE);
        check("busy_start_no_reset", bus.o_ber_reset, 0);
        set_counters(7, 500, 7, 500);
        cmd(CMD_STOP, 0);
        check("stop_snap", bus.o_state, S_SNAP);
        tick();
        set_counters(64'd99, 64'd12345, 64'd98, 64'd54321);
        read_word(3'd0, 32'd7, "stop_err_i");
        read_word(3'd2, 32'd500, "stop_bits_i");
        read_word(3'd4, 32'd7, "stop_err_q");
        read_word(3'd6, 32'd500, "stop_bits_q");

        // STOP coinciding with window reached.
        set_counters(1, 0, 1, 0);
        cmd(CMD_START, 64);
        wait_state(S_MEASURE, 20, "race_measure");
        bus.i_bits_i = 64'd64;
        bus.i_bits_q = 64'd64;
        cmd(CMD_STOP, 0);
        check("race_snap", bus.o_state, S_SNAP);
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nd += int'(bus.o_done);
        end
        check("race_one_done", nd, 1);
        check("race_done_state", bus.o_state, S_DONE);

        // CLEAR from MEASURE.
        cmd(CMD_START, 0);
        wait_state(S_MEASURE, 20, "clr_measure");
        cmd(CMD_CLEAR, 0);
        check("clr_idle", bus.o_state, S_IDLE);
        check("clr_pulse", bus.o_ber_reset, 1);
        check("clr_busy", bus.o_busy, 0);
        tick();
        check("clr_pulse_end", bus.o_ber_reset, 0);
        orAll = '0;
        for (int i = 0; i < 8; i++) begin
            bus.i_rd_en  = 1'b1;
            bus.i_rd_sel = 3'(i);
            tick();
            orAll |= bus.o_rd_data;
        end
        bus.i_rd_en = 1'b0;
        check("clr_snapshot_zero", orAll, 0);

        // SYNC timeout.
        bus.i_fase_ok_i = 1'b0;
        bus.i_fase_ok_q = 1'b1;
        cmd(CMD_START, 0);
        wait_state(S_SYNC, 20, "tmo_sync");
        n = 0;
        for (int k = 0; k < 300 && bus.o_state == S_SYNC; k++) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_state", bus.o_state, S_ERROR);
        check("tmo_flag", bus.o_timeout, 1);
        check("tmo_enable", bus.o_ber_enable, 0);
        cmd(CMD_START, 0);
        check("tmo_restart_clear", bus.o_timeout, 0);
        check("tmo_restart_state", bus.o_state, S_CLEAR);

        // Random snapshots against a word-level model.
        bus.i_fase_ok_i = 1'b1;
        bus.i_fase_ok_q = 1'b1;
        wait_state(S_MEASURE, 20, "rnd_first_measure");
        for (int it = 0; it < 8; it++) begin
            if (it != 0) begin
                cmd(CMD_START, 0);
                wait_state(S_MEASURE, 20, "rnd_measure");
            end
            model[0] = {$urandom, $urandom | 32'd1};
            model[1] = {$urandom, $urandom};
            model[2] = {$urandom, $urandom};
            model[3] = {$urandom, $urandom};
            set_counters(model[0], model[1], model[2], model[3]);
            cmd(CMD_STOP, 0);
            tick();
            set_counters({$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom}, {$urandom, $urandom});
            for (int r = 0; r < 4; r++) begin
                rsel = 3'($urandom_range(0, 7));
                rexp = 32'(model[rsel[2:1]] >> (rsel[0] ? 32 : 0));
                read_word(rsel, rexp, $sformatf("rnd%0d_sel%0d", it, rsel));
            end
        end
        read_word(3'd0, model[0][31:0], "rnd_final");

        // Reset in the middle of SYNC.
        bus.i_fase_ok_i = 1'b0;
        cmd(CMD_START, 0);
        wait_state(S_SYNC, 20, "mid_sync");
        i_reset = 1'b1;
        tick();
        check("mid_rst_state", bus.o_state, S_IDLE);
        check("mid_rst_ber_reset", bus.o_ber_reset, 0);
        check("mid_rst_enable", bus.o_ber_enable, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_done", bus.o_done, 0);
        check("mid_rst_timeout", bus.o_timeout, 0);
        check("mid_rst_rd_data", bus.o_rd_data, 0);
        check("mid_rst_rd_valid", bus.o_rd_valid, 0);
        i_reset = 1'b0;
        tick();
        read_word(3'd0, 32'd0, "mid_rst_snapshot");
`endif

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule

// File: doc/ber_ctrl.md
# ber_ctrl

Measurement sequencer for the I/Q BER counter pair on the receiver test path. It accepts commands from the MicroBlaze register interface and drives reset/enable of both BER counters. It then waits for both to report phase lock, runs a measurement window of a programmed bit count, and snapshots the four 64-bit counters atomically. The snapshot is served back as 32-bit words through a read port.

## Interface
- RST_CYCLES, 4, cycles `o_ber_reset` is held high in CLEAR (≥1)
- SYNC_TIMEOUT, 1_000_000, max cycles in SYNC before declaring timeout (≥1)
- `clock` in 1: system clock; single clock domain
- `i_reset` in 1: synchronous, active-high reset
- `i_cmd_valid` in 1: command strobe, one cycle per command
- `i_cmd` in 2: 0 NOP, 1 START, 2 STOP, 3 CLEAR
- `i_window` in 32: bits per window, sampled on accepted START; 0 = unbounded
- `i_rd_en` in 1: read request
- `i_rd_sel` in 3: word select: 0/1 ErrI lo/hi, 2/3 BitsI lo/hi, 4/5 ErrQ lo/hi, 6/7 BitsQ lo/hi
- `o_rd_data` out 32: read data
- `o_rd_valid` out 1: read data valid
- `o_ber_reset` out 1: reset to both BER counters
- `o_ber_enable` out 1: enable to both BER counters
- `i_fase_ok_i`, `i_fase_ok_q` in 1 each: phase-found flags from the counters
- `i_err_i`, `i_bits_i`, `i_err_q`, `i_bits_q` in 64 each: live counter values
- `o_state` out 3: current state code
- `o_busy` out 1: high in CLEAR, SYNC, MEASURE, SNAP
- `o_done` out 1: one-cycle pulse when a snapshot is committed
- `o_timeout` out 1: sticky, high in ERROR

## Operation
- States: IDLE(0), CLEAR(1), SYNC(2), MEASURE(3), SNAP(4), DONE(5), ERROR(6).
- IDLE/DONE/ERROR + START → CLEAR.
  - Latch `i_window`.
  - Clear `o_timeout`.
  - Keep the previous snapshot.
- CLEAR: `o_ber_reset`=1, `o_ber_enable`=0 for exactly RST_CYCLES cycles → SYNC.
- SYNC:
  - `o_ber_enable`=1.
  - When `i_fase_ok_i` & `i_fase_ok_q` are both high → MEASURE.
  - When the cycle counter reaches SYNC_TIMEOUT → ERROR.
- MEASURE:
  - `o_ber_enable`=1.
  - When window≠0 and `i_bits_i` ≥ window and `i_bits_q` ≥ window (unsigned, 64-bit compare, window zero-extended) → SNAP.
- STOP in SYNC or MEASURE → SNAP. The snapshot is taken even if not yet locked.
- STOP in any other state is ignored.
- SNAP:
  - Latch all four 64-bit inputs in the same cycle.
  - `o_ber_enable`=0.
  - Go to DONE.
- The counters keep counting after enable drops, so the snapshot registers are the only valid result.
- DONE: `o_ber_enable`=0, idle until a command arrives.
- ERROR: `o_timeout`=1, `o_ber_enable`=0.
- CLEAR command, any state → IDLE.
  - Zero the snapshot.
  - Clear `o_timeout`.
  - Pulse `o_ber_reset` for one cycle.
- START while busy is ignored.
- Simultaneous events:
  - STOP and window-reached in the same cycle → single SNAP.
  - CLEAR and any other condition in the same cycle → CLEAR wins.
- Reads are independent of state. Data always comes from the snapshot, never from live inputs, so hi/lo halves are always coherent.

## Timing
- Reset values:
  - state IDLE
  - `o_ber_reset`=0, `o_ber_enable`=0, `o_busy`=0, `o_done`=0, `o_timeout`=0
  - `o_rd_data`=0, `o_rd_valid`=0
  - snapshot=0, window=0
- A command registered at edge n changes state at edge n; outputs are registered and reflect the new state after edge n.
- Lock detect → MEASURE: 1 cycle. Window reached → SNAP: 1 cycle. SNAP → DONE: 1 cycle.
- `o_done` is high during the cycle after SNAP.
- Read: `i_rd_en` at edge n → `o_rd_data`/`o_rd_valid` valid after edge n (1-cycle latency).
  - Back-to-back reads every cycle are allowed.
  - `o_rd_valid`=0 when `i_rd_en`=0; `o_rd_data` holds its last value.
- SYNC timeout counter is 32 bits, saturating, and cleared on entry to SYNC.
- `i_reset` mid-operation returns to the reset values on the next edge.

## Configuration
- `BER_CTRL_AUTORESTART_EN`
  - Defined: DONE automatically → CLEAR on the next cycle using the latched window, giving continuous windows with an `o_done` pulse per window. Each new snapshot overwrites the previous one. STOP in DONE is accepted and holds in IDLE.
  - Undefined: DONE waits for a command, as described in Operation.

## Structure
- `ber_ctrl_pkg`: state encoding, command codes (CMD_NOP/START/STOP/CLEAR), read-select codes, 64-bit counter width constant.
- Sub-module `ber_snapshot`:
  - 4×64-bit capture registers with a capture strobe and a clear strobe.
  - Registered 8:1 32-bit read mux with valid.
- The FSM and timers stay in `ber_ctrl`.

## Test plan
- Lock and window complete:
  - Stimulus: START, window=1000; assert both fase_ok 20 cycles after CLEAR ends; ramp bits to 1000.
  - Response: SNAP then `o_done` pulse; reads of sel 2/3 return 1000 and 0.
- Timeout: SYNC_TIMEOUT=100, fase_ok held low → ERROR exactly 100 cycles after SYNC entry; `o_timeout`=1; `o_ber_enable`=0.
- Early STOP: STOP in MEASURE with bits=500, err=7 → snapshot shows 500 and 7; live inputs changing afterwards do not alter reads.
- Edge cases:
  - Window=0 runs until STOP.
  - STOP and window-reached in the same cycle give exactly one `o_done`.
  - START while busy has no effect.
- CLEAR and reset:
  - CLEAR from MEASURE → IDLE, all 8 words read 0, one-cycle `o_ber_reset`.
  - `i_reset` mid-SYNC → all outputs at their reset values.
- Auto-restart (`BER_CTRL_AUTORESTART_EN` defined): window=64 → three consecutive `o_done` pulses, each preceded by RST_CYCLES of `o_ber_reset`.
